tbuf_alloc_sched: RTL and testbench

//  Schedules buffer-address allocations into the per-thread tbuf CAM (2 threads, WIDTH-bit addresses).

---
 rtl/tbuf_alloc_sched.sv | 133 +++++++++++++
 tb/tb_tbuf_alloc_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tbuf_alloc_sched.sv
// Two-thread allocation scheduler for the tbuf CAM: per-thread request queues,
// round-robin grant, one CAM lookup per cycle, park-on-full until exception flush.
module tbuf_alloc_sched #(
    parameter int WIDTH  = 11,
    parameter int QDEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             except,
    input  logic             except_thread,
    input  logic             req_valid0,
    input  logic [WIDTH-1:0] req_addr0,
    output logic             req_ready0,
    input  logic             req_valid1,
    input  logic [WIDTH-1:0] req_addr1,
    output logic             req_ready1,
    output logic [WIDTH-1:0] cam_new_addr,
    output logic             cam_new_thread,
    output logic             cam_new_en,
    input  logic             cam_chk_match,
    input  logic             cam_free,
    output logic             done_valid,
    output logic             done_thread,
    output logic             done_hit,
    output logic             blocked0,
    output logic             blocked1
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, LOOKUP} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] qmem [2][QDEPTH];
    logic [PW-1:0]    rptr [2];
    logic [PW-1:0]    wptr [2];
    logic [CW-1:0]    cnt  [2];
    logic [CW-1:0]    remain [2];
    logic [WIDTH-1:0] head [2];
    logic [WIDTH-1:0] req_addr [2];
    logic [1:0]       req_valid;
    logic [1:0]       blocked;
    logic [1:0]       full, ready, push, pop, flush, elig, blk_set;
    logic             rr_last, cur_thread;
    logic [WIDTH-1:0] cur_addr;
    logic             active, kill, hit, alloc, block;
    logic             grant_any, grant;
    logic [WIDTH-1:0] grant_addr;

    assign req_addr[0] = req_addr0;
    assign req_addr[1] = req_addr1;
    assign req_valid   = {req_valid1, req_valid0};
    assign req_ready0  = ready[0];
    assign req_ready1  = ready[1];
    assign blocked0    = blocked[0];
    assign blocked1    = blocked[1];
    assign cam_new_addr   = cur_addr;
    assign cam_new_thread = cur_thread;

    always_comb begin
        state_nxt  = IDLE;
        active     = (state == LOOKUP);
        flush      = {except && except_thread, except && !except_thread};
        kill       = active && flush[cur_thread];
        hit        = active && !kill && cam_chk_match;
        alloc      = active && !kill && !cam_chk_match && cam_free;
        block      = active && !kill && !cam_chk_match && !cam_free;
        cam_new_en = alloc;
        full = '0; ready = '0; push = '0; pop = '0; blk_set = '0; elig = '0;
        for (int t = 0; t < 2; t++) begin
            full[t]    = (cnt[t] == CW'(QDEPTH));
            ready[t]   = !full[t] && !flush[t];
            push[t]    = req_valid[t] && ready[t];
            pop[t]     = (hit || alloc) && (cur_thread == 1'(t));
            blk_set[t] = block && (cur_thread == 1'(t));
            remain[t]  = cnt[t] - CW'(pop[t]);
            // Eligibility looks past this cycle's pop/park so lookups can run back to back;
            // an empty queue forwards the address being accepted right now.
            elig[t]    = !flush[t] && !blocked[t] && !blk_set[t] && ((remain[t] != '0) || push[t]);
            head[t]    = (remain[t] == '0) ? req_addr[t] : qmem[t][rptr[t] + PW'(pop[t])];
        end
        grant_any  = |elig;
        grant      = (elig == 2'b11) ? !rr_last : elig[1];
        grant_addr = head[grant];
        if (grant_any) state_nxt = LOOKUP;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_last     <= 1'b1;
            cur_thread  <= 1'b0;
            blocked     <= '0;
            done_valid  <= 1'b0;
            done_thread <= 1'b0;
            done_hit    <= 1'b0;
            for (int t = 0; t < 2; t++) begin
                cnt[t]  <= '0;
                rptr[t] <= '0;
                wptr[t] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                rr_last    <= grant;
                cur_thread <= grant;
            end
            done_valid  <= hit || alloc;
            done_thread <= cur_thread;
            done_hit    <= hit;
            for (int t = 0; t < 2; t++) begin
                if (flush[t]) begin
                    cnt[t]     <= '0;
                    rptr[t]    <= '0;
                    wptr[t]    <= '0;
                    blocked[t] <= 1'b0;
                end else begin
                    if (push[t]) wptr[t] <= wptr[t] + PW'(1);
                    if (pop[t])  rptr[t] <= rptr[t] + PW'(1);
                    cnt[t] <= cnt[t] + CW'(push[t]) - CW'(pop[t]);
                    if (blk_set[t]) blocked[t] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant_any) cur_addr <= grant_addr;
        for (int t = 0; t < 2; t++) begin
            if (push[t]) qmem[t][wptr[t]] <= req_addr[t];
        end
    end
endmodule

// File: tb/tb_tbuf_alloc_sched.sv
// Bench for tbuf_alloc_sched: queue-level reference model plus a modelled CAM
// (4 entries per thread), directed scenarios followed by random traffic.
module tb_tbuf_alloc_sched;
    localparam int W   = 11;
    localparam int QD  = 2;
    localparam int CAP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         except = 1'b0, except_thread = 1'b0;
    logic         req_valid0 = 1'b0, req_valid1 = 1'b0;
    logic [W-1:0] req_addr0 = '0, req_addr1 = '0;
    logic         req_ready0, req_ready1;
    logic [W-1:0] cam_new_addr;
    logic         cam_new_thread, cam_new_en;
    logic         cam_chk_match = 1'b0, cam_free = 1'b0;
    logic         done_valid, done_thread, done_hit;
    logic         blocked0, blocked1;

    tbuf_alloc_sched #(.WIDTH(W), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .except(except), .except_thread(except_thread),
        .req_valid0(req_valid0), .req_addr0(req_addr0), .req_ready0(req_ready0),
        .req_valid1(req_valid1), .req_addr1(req_addr1), .req_ready1(req_ready1),
        .cam_new_addr(cam_new_addr), .cam_new_thread(cam_new_thread), .cam_new_en(cam_new_en),
        .cam_chk_match(cam_chk_match), .cam_free(cam_free),
        .done_valid(done_valid), .done_thread(done_thread), .done_hit(done_hit),
        .blocked0(blocked0), .blocked1(blocked1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: request queues, CAM contents, parked flags, pending lookup, pending done.
    logic [W-1:0] mq [2][$];
    logic [W-1:0] cam_res [2][$];
    bit           mblk [2];
    bit           mrr, mlook, mthr, mdv, mdt, mdh;
    logic [W-1:0] maddr;

    bit           obs_en, obs_thr, obs_dv, obs_dt, obs_dh, obs_b0, obs_r0;
    logic [W-1:0] obs_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cam_has(input bit t, input logic [W-1:0] a);
        for (int i = 0; i < cam_res[t].size(); i++)
            if (cam_res[t][i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int t = 0; t < 2; t++) begin
            mq[t].delete();
            cam_res[t].delete();
            mblk[t] = 1'b0;
        end
        mrr = 1'b1; mlook = 1'b0; mthr = 1'b0; mdv = 1'b0; mdt = 1'b0; mdh = 1'b0;
    endtask

    task automatic step(input bit v0, input logic [W-1:0] a0, input bit v1, input logic [W-1:0] a1,
                        input bit exc, input bit et);
        bit r0, r1, kill, hitm, allocm, blockm, e0, e1, g;
        @(negedge clk);
        req_valid0 = v0; req_addr0 = a0; req_valid1 = v1; req_addr1 = a1;
        except = exc; except_thread = et;
        if (mlook) begin
            cam_chk_match = cam_has(mthr, maddr);
            cam_free      = (cam_res[mthr].size() < CAP);
        end else begin
            cam_chk_match = 1'($urandom);
            cam_free      = 1'($urandom);
        end
        #1;
        r0 = (mq[0].size() < QD) && !(exc && !et);
        r1 = (mq[1].size() < QD) && !(exc && et);
        kill   = mlook && exc && (et == mthr);
        hitm   = mlook && !kill && cam_chk_match;
        allocm = mlook && !kill && !cam_chk_match && cam_free;
        blockm = mlook && !kill && !cam_chk_match && !cam_free;
        chk("ready0", req_ready0, r0);
        chk("ready1", req_ready1, r1);
        chk("new_en", cam_new_en, allocm);
        if (mlook && !kill) begin
            chk("new_addr", cam_new_addr, maddr);
            chk("new_thread", cam_new_thread, mthr);
        end
        chk("blocked0", blocked0, mblk[0]);
        chk("blocked1", blocked1, mblk[1]);
        chk("done_valid", done_valid, mdv);
        if (mdv) begin
            chk("done_thread", done_thread, mdt);
            chk("done_hit", done_hit, mdh);
        end
        obs_en = cam_new_en; obs_thr = cam_new_thread; obs_addr = cam_new_addr;
        obs_dv = done_valid; obs_dt = done_thread; obs_dh = done_hit;
        obs_b0 = blocked0; obs_r0 = req_ready0;
        // advance the model across the coming clock edge
        mdv = hitm || allocm; mdt = mthr; mdh = hitm;
        if (hitm || allocm) void'(mq[mthr].pop_front());
        if (allocm) cam_res[mthr].push_back(maddr);
        if (blockm) mblk[mthr] = 1'b1;
        if (v0 && r0) mq[0].push_back(a0);
        if (v1 && r1) mq[1].push_back(a1);
        if (exc) begin
            mq[et].delete();
            cam_res[et].delete();
            mblk[et] = 1'b0;
        end
        e0 = (mq[0].size() != 0) && !mblk[0];
        e1 = (mq[1].size() != 0) && !mblk[1];
        g  = (e0 && e1) ? !mrr : e1;
        mlook = e0 || e1;
        if (mlook) begin
            mthr  = g;
            maddr = mq[g][0];
            mrr   = g;
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0; except = 1'b0;
        #1;
        chk("rst_new_en", cam_new_en, 0);
        chk("rst_done", done_valid, 0);
        chk("rst_blocked0", blocked0, 0);
        chk("rst_blocked1", blocked1, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        model_clear();
        #1;
        chk("rel_ready0", req_ready0, 1);
        chk("rel_ready1", req_ready1, 1);
    endtask

    initial begin
        model_clear();
        // scenario 1 and 2: first allocation, then the same address hits
        do_reset();
        step(1'b1, 11'h05A, 1'b0, '0, 1'b0, 1'b0);
        idle();
        chk("s1_new_en", obs_en, 1);
        chk("s1_new_addr", obs_addr, 11'h05A);
        chk("s1_new_thread", obs_thr, 0);
        idle();
        chk("s1_done_valid", obs_dv, 1);
        chk("s1_done_hit", obs_dh, 0);
        step(1'b1, 11'h05A, 1'b0, '0, 1'b0, 1'b0);
        idle();
        chk("s2_new_en", obs_en, 0);
        idle();
        chk("s2_done_valid", obs_dv, 1);
        chk("s2_done_hit", obs_dh, 1);
        chk("s2_done_thread", obs_dt, 0);

        // scenario 3: thread 0 fills its CAM half and parks; thread 1 unaffected
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 11'h010 + 11'(i), 1'b0, '0, 1'b0, 1'b0);
            idle();
        end
        step(1'b1, 11'h100, 1'b0, '0, 1'b0, 1'b0);
        idle();
        chk("s3_park_no_en", obs_en, 0);
        idle();
        chk("s3_blocked0", obs_b0, 1);
        step(1'b0, '0, 1'b1, 11'h200, 1'b0, 1'b0);
        idle();
        chk("s3_t1_en", obs_en, 1);
        chk("s3_t1_thread", obs_thr, 1);
        step(1'b1, 11'h123, 1'b0, '0, 1'b1, 1'b0);
        chk("s3_ready0_flush", obs_r0, 0);
        idle();
        chk("s3_unblocked", obs_b0, 0);
        chk("s3_q0_empty", obs_en, 0);
        idle();

        // scenario 4: both threads streaming, grants alternate starting with thread 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 11'h300 + 11'(i), 1'b1, 11'h400 + 11'(i), 1'b0, 1'b0);
            if (i > 0) begin
                chk("s4_en", obs_en, 1);
                chk("s4_thread", obs_thr, (i % 2 == 1) ? 0 : 1);
            end
        end
        repeat (4) idle();

        // scenario 5: flush of thread 1 kills its lookup; thread 0 proceeds
        do_reset();
        step(1'b0, '0, 1'b1, 11'h210, 1'b0, 1'b0);
        step(1'b1, 11'h011, 1'b0, '0, 1'b1, 1'b1);
        chk("s5_killed_en", obs_en, 0);
        idle();
        chk("s5_no_done", obs_dv, 0);
        chk("s5_t0_en", obs_en, 1);
        chk("s5_t0_addr", obs_addr, 11'h011);
        idle();
        chk("s5_t0_done", obs_dv, 1);
        chk("s5_t0_done_thread", obs_dt, 0);

        // scenario 6: asynchronous reset in the middle of a lookup
        do_reset();
        step(1'b1, 11'h077, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        req_valid0 = 1'b0; cam_chk_match = 1'b0; cam_free = 1'b1;
        #1;
        chk("s6_pre_en", cam_new_en, 1);
        rst = 1'b0;
        #1;
        chk("s6_en_falls", cam_new_en, 0);
        repeat (2) @(posedge clk);
        #4 rst = 1'b1;
        model_clear();
        #1;
        chk("s6_ready0", req_ready0, 1);
        chk("s6_ready1", req_ready1, 1);
        chk("s6_blocked0", blocked0, 0);
        chk("s6_blocked1", blocked1, 0);
        repeat (3) idle();

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 2) != 0, 11'($urandom_range(0, 7)),
                 $urandom_range(0, 2) != 0, 11'h400 | 11'($urandom_range(0, 7)),
                 $urandom_range(0, 11) == 0, 1'($urandom));
        end
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
